// File: rtl/load_store_unit_if.sv
// Request/response and word-memory signals of the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_illegal;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // The load/store unit itself.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        output mem_rw, mem_addr, mem_wdata
    );

    // The core plus word memory driving the unit.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        input  mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, sub-word stores done as read-modify-write.
module load_store_unit (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_e;

    localparam logic [2:0] F3B  = 3'b000;
    localparam logic [2:0] F3H  = 3'b001;
    localparam logic [2:0] F3W  = 3'b010;
    localparam logic [2:0] F3BU = 3'b100;
    localparam logic [2:0] F3HU = 3'b101;

    state_e      r_state, w_state_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wdata, r_merged, r_rdata;
    logic        r_misaligned, r_illegal;

    logic        w_accept, w_illegal, w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data, w_merged;

    // Classify the incoming request; illegal takes priority over misaligned.
    always_comb begin
        w_accept  = bus.req_valid && (r_state == StIdle);
        w_illegal = 1'b0;
        case (bus.req_funct3)
            3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
            F3BU, F3HU:             w_illegal = bus.req_we;
            default:                w_illegal = 1'b0;
        endcase
        w_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3 == F3W) && (bus.req_addr[1:0] != 2'b00));
    end

    // Little-endian lane extraction and extension for loads.
    always_comb begin
        unique case (r_addr[1:0])
            2'd0: w_byte = bus.mem_rdata[7:0];
            2'd1: w_byte = bus.mem_rdata[15:8];
            2'd2: w_byte = bus.mem_rdata[23:16];
            2'd3: w_byte = bus.mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_funct3)
            F3B:     w_load_data = {{24{w_byte[7]}}, w_byte};
            F3H:     w_load_data = {{16{w_half[15]}}, w_half};
            F3BU:    w_load_data = {24'h0, w_byte};
            F3HU:    w_load_data = {16'h0, w_half};
            default: w_load_data = bus.mem_rdata;
        endcase
    end

    // Merge store data into the fetched word for SB/SH.
    always_comb begin
        w_merged = bus.mem_rdata;
        if (r_funct3 == F3B) begin
            unique case (r_addr[1:0])
                2'd0: w_merged[7:0]   = r_wdata[7:0];
                2'd1: w_merged[15:8]  = r_wdata[7:0];
                2'd2: w_merged[23:16] = r_wdata[7:0];
                2'd3: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merged[31:16] = r_wdata[15:0];
        end else begin
            w_merged[15:0] = r_wdata[15:0];
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = (w_illegal || w_misaligned) ? StResp : StAccess;
                end
            end
            StAccess: w_state_next = (r_we && (r_funct3 != F3W)) ? StWrite : StResp;
            StWrite:  w_state_next = StResp;
            StResp:   w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    // Request latch, response fields and merged store word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_merged     <= 32'h0;
            r_rdata      <= 32'h0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (w_accept) begin
            r_we         <= bus.req_we;
            r_funct3     <= bus.req_funct3;
            r_addr       <= bus.req_addr;
            r_wdata      <= bus.req_wdata;
            r_rdata      <= 32'h0;
            r_illegal    <= w_illegal;
            r_misaligned <= !w_illegal && w_misaligned;
        end else if (r_state == StAccess) begin
            r_merged <= w_merged;
            if (!r_we) r_rdata <= w_load_data;
        end
    end

    // Outputs decode from registered state only, so mem_rw never glitches on request inputs.
    always_comb begin
        bus.req_ready       = (r_state == StIdle);
        bus.resp_valid      = (r_state == StResp);
        bus.resp_rdata      = r_rdata;
        bus.resp_misaligned = r_misaligned;
        bus.resp_illegal    = r_illegal;
        bus.mem_rw          = 1'b0;
        bus.mem_addr        = 32'h0;
        bus.mem_wdata       = 32'h0;
        if (r_state == StAccess) begin
            bus.mem_addr = r_addr;
            if (r_we && (r_funct3 == F3W)) begin
                bus.mem_rw    = 1'b1;
                bus.mem_wdata = r_wdata;
            end
        end else if (r_state == StWrite) begin
            bus.mem_rw    = 1'b1;
            bus.mem_addr  = r_addr;
            bus.mem_wdata = r_merged;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256-word behavioural memory.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    load_store_unit_if u_if ();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic        pl_we = 1'b0;
    logic [7:0]  pl_idx = 8'h0;
    logic [31:0] pl_d = 32'h0;
    int          rw_total = 0;

    assign u_if.mem_rdata = mem[u_if.mem_addr[9:2]];

    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] <= pl_d;
        else if (u_if.mem_rw) mem[u_if.mem_addr[9:2]] <= u_if.mem_wdata;
        if (u_if.mem_rw) rw_total <= rw_total + 1;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          rw_start;
    int          got_lat, got_rwc;
    logic [31:0] got_rd;
    logic        got_mis, got_ill;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = idx; pl_d = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic set_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
        u_if.req_we = we; u_if.req_funct3 = f3; u_if.req_addr = a; u_if.req_wdata = wd;
    endtask

    // Present a request at the current negedge; it is accepted at the next posedge.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        check("ready_before_req", 32'(u_if.req_ready), 32'd1);
        set_req(we, f3, a, wd);
        u_if.req_valid = 1'b1;
        rw_start = rw_total;
        @(posedge clk);
        #1;
        u_if.req_valid = 1'b0;
        set_req(~we, 3'b111, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    endtask

    // Sample each cycle after acceptance until resp_valid, bounded.
    task automatic wait_resp();
        got_lat = 0; got_rwc = 0; got_rd = 32'hX; got_mis = 1'bX; got_ill = 1'bX;
        for (int c = 1; c <= 8 && got_lat == 0; c++) begin
            @(negedge clk);
            if (u_if.mem_rw && got_rwc == 0) got_rwc = c;
            if (u_if.resp_valid) begin
                got_lat = c;
                got_rd  = u_if.resp_rdata;
                got_mis = u_if.resp_misaligned;
                got_ill = u_if.resp_illegal;
            end
        end
        @(negedge clk);
        check("resp_one_cycle", 32'(u_if.resp_valid), 32'd0);
    endtask

    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                       input logic [31:0] exp_rd, input logic exp_mis, input logic exp_ill,
                       input int exp_rwn);
        do_req(we, f3, a, wd);
        wait_resp();
        check({tag, "_lat"}, 32'(got_lat), 32'(exp_lat));
        check({tag, "_rdata"}, got_rd, exp_rd);
        check({tag, "_mis"}, 32'(got_mis), 32'(exp_mis));
        check({tag, "_ill"}, 32'(got_ill), 32'(exp_ill));
        check({tag, "_rw_count"}, 32'(rw_total - rw_start), 32'(exp_rwn));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   busy;
        int   lat;
        logic got;
        logic [31:0] rd;
        time  t_acc [4];

        u_if.req_valid = 1'b0;
        set_req(1'b0, 3'b000, 32'h0, 32'h0);
        #2;
        check("rst_ready", 32'(u_if.req_ready), 32'd1);
        check("rst_resp_valid", 32'(u_if.resp_valid), 32'd0);
        check("rst_rdata", u_if.resp_rdata, 32'h0);
        check("rst_flags", {30'h0, u_if.resp_misaligned, u_if.resp_illegal}, 32'h0);
        check("rst_mem_rw", 32'(u_if.mem_rw), 32'd0);
        check("rst_mem_addr", u_if.mem_addr, 32'h0);
        check("rst_mem_wdata", u_if.mem_wdata, 32'h0);

        preload(8'd4, 32'h8000_00F0);
        preload(8'd8, 32'h1122_3344);
        preload(8'd12, 32'hCAFE_BABE);
        preload(8'd16, 32'h0000_0000);

        // First acceptance on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        run("lb", 1'b0, 3'b000, 32'h10, 32'h0, 2, 32'hFFFF_FFF0, 1'b0, 1'b0, 0);
        run("lbu", 1'b0, 3'b100, 32'h10, 32'h0, 2, 32'h0000_00F0, 1'b0, 1'b0, 0);
        run("lh", 1'b0, 3'b001, 32'h12, 32'h0, 2, 32'hFFFF_8000, 1'b0, 1'b0, 0);
        run("ill_load", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b0, 1'b1, 0);

        run("sb", 1'b1, 3'b000, 32'h21, 32'h0000_00AB, 3, 32'h0, 1'b0, 1'b0, 1);
        check("sb_rw_cycle", 32'(got_rwc), 32'd2);
        check("sb_mem", mem[8], 32'h1122_AB44);

        run("sw_mis", 1'b1, 3'b010, 32'h22, 32'h5555_5555, 1, 32'h0, 1'b1, 1'b0, 0);
        check("sw_mis_mem", mem[8], 32'h1122_AB44);
        run("lh_mis", 1'b0, 3'b001, 32'h13, 32'h0, 1, 32'h0, 1'b1, 1'b0, 0);
        run("ill_store", 1'b1, 3'b100, 32'h20, 32'h0000_0077, 1, 32'h0, 1'b0, 1'b1, 0);
        check("ill_store_mem", mem[8], 32'h1122_AB44);

        // SH interrupted by reset during WRITE.
        do_req(1'b1, 3'b001, 32'h30, 32'h0000_1234);
        @(negedge clk);
        @(negedge clk);
        check("sh_write_rw", 32'(u_if.mem_rw), 32'd1);
        check("sh_write_wdata", u_if.mem_wdata, 32'hCAFE_1234);
        rst_n = 1'b0;
        #1;
        check("rstw_mem_rw", 32'(u_if.mem_rw), 32'd0);
        check("rstw_mem_addr", u_if.mem_addr, 32'h0);
        check("rstw_ready", 32'(u_if.req_ready), 32'd1);
        check("rstw_resp_valid", 32'(u_if.resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        busy = 0;
        for (int i = 0; i < 4; i++) begin
            if (u_if.resp_valid) busy++;
            @(negedge clk);
        end
        check("rstw_no_resp", 32'(busy), 32'd0);
        check("rstw_mem", mem[12], 32'hCAFE_BABE);
        check("rstw_ready_after", 32'(u_if.req_ready), 32'd1);

        // Back-to-back SW/LW with req_valid held high.
        set_req(1'b1, 3'b010, 32'h40, 32'hA5A5_0001);
        u_if.req_valid = 1'b1;
        rw_start = rw_total;
        busy = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 8 && !got; i++) begin
                if (u_if.req_ready) got = 1'b1;
                else @(negedge clk);
            end
            check("b2b_ready_seen", 32'(got), 32'd1);
            @(posedge clk);
            t_acc[k] = $time;
            @(negedge clk);
            if (k == 0)      set_req(1'b0, 3'b010, 32'h40, 32'h0);
            else if (k == 1) set_req(1'b1, 3'b010, 32'h40, 32'h5A5A_0002);
            else if (k == 2) set_req(1'b0, 3'b010, 32'h40, 32'h0);
            else             u_if.req_valid = 1'b0;
            lat = 0;
            rd  = 32'h0;
            for (int c = 1; c <= 6 && lat == 0; c++) begin
                if (c > 1) @(negedge clk);
                if (u_if.resp_valid) begin
                    lat = c;
                    rd  = u_if.resp_rdata;
                end else if (u_if.req_ready) begin
                    busy++;
                end
            end
            check("b2b_lat", 32'(lat), 32'd2);
            if (k == 1) check("b2b_lw1", rd, 32'hA5A5_0001);
            if (k == 3) check("b2b_lw2", rd, 32'h5A5A_0002);
            if (k > 0) check("b2b_gap", 32'(t_acc[k] - t_acc[k-1]), 32'd30);
        end
        check("b2b_busy_ready", 32'(busy), 32'd0);
        check("b2b_rw_count", 32'(rw_total - rw_start), 32'd2);
        check("b2b_mem", mem[16], 32'h5A5A_0002);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL run on one clock and SHALL use an asynchronous, active-low reset; the ports are listed below, clock and reset first.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  core presents a memory request.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load result; 0 for stores and errors.
- resp_misaligned  output  1  access was not naturally aligned.
- resp_illegal  output  1  funct3 was 011, 110 or 111, or was 100/101 with req_we=1.
- mem_rw  output  1  write strobe to the word memory; the write commits at the rising edge ending that cycle.
- mem_addr  output  32  address to the word memory; the memory uses bits [9:2].
- mem_wdata  output  32  full word to write.
- mem_rdata  input  32  combinational read data of mem_addr.

Function
REQ-002 The FSM SHALL have exactly these states: IDLE, ACCESS, WRITE, RESP.
REQ-003 req_ready SHALL be 1 only in IDLE.
REQ-004 A request SHALL be accepted at a rising edge where req_valid=1 and req_ready=1.
- On acceptance, req_we, req_funct3, req_addr and req_wdata SHALL be latched.
- Request inputs SHALL be ignored outside acceptance.
REQ-005 Check order at acceptance:
- Illegal funct3 SHALL go to RESP with resp_illegal=1.
- Otherwise, a misaligned access SHALL go to RESP with resp_misaligned=1.
- Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=00.
- Otherwise the FSM SHALL go to ACCESS.
- Error paths SHALL never assert mem_rw.
REQ-006 In ACCESS, mem_addr SHALL equal the latched address.
REQ-007 Loads in ACCESS:
- The block SHALL select a lane from mem_rdata, little-endian: byte lane = addr[1:0], half lane = addr[1].
- B/H SHALL sign-extend; BU/HU SHALL zero-extend; W SHALL pass unchanged.
- The result SHALL be registered into resp_rdata, and the FSM SHALL go to RESP.
REQ-008 SW in ACCESS SHALL assert mem_rw=1 with mem_wdata = latched wdata, then go to RESP.
REQ-009 SB/SH in ACCESS (read-modify-write):
- mem_rw SHALL be 0.
- The block SHALL register a merged word: mem_rdata with the addressed byte/half lane replaced by wdata[7:0] or wdata[15:0].
- The FSM SHALL then go to WRITE.
REQ-010 WRITE SHALL assert mem_rw=1, mem_addr = latched address and mem_wdata = merged word, then go to RESP.
REQ-011 RESP SHALL assert resp_valid=1 for exactly one cycle, then return to IDLE.
- The response fields SHALL be held stable during that cycle.
- They SHALL be cleared to 0 on the next acceptance.
REQ-012 Latency, counted in cycles after the acceptance edge in which resp_valid=1:
- error paths: cycle 1.
- loads and SW: cycle 2.
- SB and SH: cycle 3.
REQ-013 Back-to-back operation:
- A new request SHALL be acceptable at the edge that leaves RESP only if it arrives in the following IDLE cycle.
- The block SHALL NOT accept during RESP, so throughput is one request per (latency+1) cycles.
REQ-014 Outside ACCESS and WRITE:
- mem_rw SHALL be 0.
- mem_addr and mem_wdata SHALL be 0.
REQ-015 mem_rw SHALL be decoded combinationally from state only and SHALL be glitch-free with respect to the request inputs.
REQ-016 At most one mem_rw cycle SHALL occur per accepted request.

Reset
REQ-017 While rst_n=0, the block SHALL force all of the following regardless of clk:
- state=IDLE, req_ready=1, resp_valid=0.
- resp_rdata=0, resp_misaligned=0, resp_illegal=0.
- mem_rw=0, mem_addr=0, mem_wdata=0.
REQ-018 Reset asserted in ACCESS or WRITE SHALL drop mem_rw immediately, so no write commits.
- The in-flight request SHALL be discarded with no response.
REQ-019 After rst_n deasserts, the first acceptance SHALL be possible at the first rising edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- LB, memory word 0x8000_00F0 at 0x10 -> addr 0x10 returns 0xFFFF_FFF0; LBU returns 0x0000_00F0; LH at 0x12 returns 0xFFFF_8000; resp_valid in cycle 2.
- SB, wdata 0x0000_00AB at 0x21, memory word 0x1122_3344 at 0x20 -> exactly one mem_rw cycle in cycle 2; memory word becomes 0x1122_AB44; resp_valid in cycle 3.
- SW at 0x22 -> resp_misaligned=1 in cycle 1; mem_rw never asserted; memory unchanged. LH at 0x13 -> resp_misaligned=1.
- funct3=011 load, and funct3=100 store -> resp_illegal=1, resp_misaligned=0, resp_rdata=0, no mem_rw.
- SH in progress, rst_n pulsed low during WRITE -> mem_rw falls while rst_n is low; target word unchanged; no resp_valid; IDLE with req_ready=1.
- req_valid held high continuously with alternating SW/LW to the same address -> each LW returns the preceding SW data; no request is accepted while req_ready=0.
